// File: rtl/int8_dotp_instr_pkg.sv
// -----------------------------------------------------------------------------
// int8_dotp_instr_pkg
// Shared types and helpers for the INT8 packed-SIMD dot-product unit:
//   dotp_opcode_t     - operation encoding (ILLEGAL, DOTP8, DOTP8_SAT, DOTP8_CLIP)
//   INT8_MIN/INT8_MAX - int8 clip bounds
//   opcode_to_string  - printable opcode name
//   saturate          - signed clamp of a wide value to a given target width
// -----------------------------------------------------------------------------
package int8_dotp_instr_pkg;

    typedef enum logic [1:0] {
        ILLEGAL    = 2'd0,
        DOTP8      = 2'd1,
        DOTP8_SAT  = 2'd2,
        DOTP8_CLIP = 2'd3
    } dotp_opcode_t;

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    // Working width of saturate(); wide enough for any XLEN+1 intermediate.
    localparam int unsigned SAT_W = 128;

    function automatic string opcode_to_string(input dotp_opcode_t op);
        case (op)
            DOTP8:      return "DOTP8";
            DOTP8_SAT:  return "DOTP8_SAT";
            DOTP8_CLIP: return "DOTP8_CLIP";
            default:    return "ILLEGAL";
        endcase
    endfunction

    // Clamp val to the signed range of a width-bit number; the result is
    // returned sign-extended to SAT_W bits.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] val,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        max_v = signed'((SAT_W'(1) << (width - 1)) - SAT_W'(1));
        min_v = ~max_v;
        res   = val;
        if (val > max_v) begin
            res = max_v;
        end else if (val < min_v) begin
            res = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/int8_dotp_lane_mul.sv
// -----------------------------------------------------------------------------
// int8_dotp_lane_mul
// Combinational array of NUM_LANES signed ELEM_W x ELEM_W multipliers.
// Ports:
//   a, b  - packed lanes, lane 0 in the low bits
//   prod  - packed signed products, 2*ELEM_W bits per lane, lane 0 lowest
// -----------------------------------------------------------------------------
module int8_dotp_lane_mul #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ELEM_W    = 8,
    parameter int unsigned NUM_LANES = XLEN / ELEM_W
) (
    input  logic [XLEN-1:0]                 a,
    input  logic [XLEN-1:0]                 b,
    output logic [NUM_LANES*2*ELEM_W-1:0]   prod
);

    localparam int unsigned PROD_W = 2 * ELEM_W;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic signed [ELEM_W-1:0] ea;
        logic signed [ELEM_W-1:0] eb;
        assign ea = signed'(a[i*ELEM_W +: ELEM_W]);
        assign eb = signed'(b[i*ELEM_W +: ELEM_W]);
        // Operands sign-extended first so the product is exact at PROD_W.
        assign prod[i*PROD_W +: PROD_W] = PROD_W'(PROD_W'(ea) * PROD_W'(eb));
    end

endmodule

// File: rtl/int8_dotp_unit.sv
// -----------------------------------------------------------------------------
// int8_dotp_unit
// Two-stage signed packed-SIMD INT8 dot-product-accumulate unit:
//   result = rd + sum(a_i * b_i) with wrap, 32-bit saturate or int8 clip.
// Stage 1 registers lane products, stage 2 reduces, accumulates and rounds
// to the result register. Valid/ready on both sides, 1 op/cycle, 2-cycle
// latency, in-order, hartid/id/rd_addr carried with each op.
// Ports:
//   clk_i, rst_i                   - clock, synchronous active-high reset
//   in_valid_i / in_ready_o        - request handshake
//   rs1_i, rs2_i, rd_i, opcode_i   - operands and operation
//   hartid_i, id_i, rd_addr_i      - metadata
//   out_valid_o / out_ready_i      - result handshake
//   result_o, we_o                 - result and write-enable qualifier
//   rd_addr_o, hartid_o, id_o      - metadata echo
// Optional (GARUDA_DOTP_SAT_FLAG_EN):
//   sat_o      - sticky flag, set when a clamped SAT/CLIP result retires
//   sat_clr_i  - clears sat_o (a same-cycle set wins)
// -----------------------------------------------------------------------------
module int8_dotp_unit
    import int8_dotp_instr_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ELEM_W    = 8,
    parameter int unsigned NUM_LANES = XLEN / ELEM_W,
    parameter type         opcode_t  = dotp_opcode_t,
    parameter type         hartid_t  = logic [1:0],
    parameter type         id_t      = logic [2:0]
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   rd_i,
    input  opcode_t           opcode_i,
    input  hartid_t           hartid_i,
    input  id_t               id_i,
    input  logic [4:0]        rd_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic              we_o,
    output logic [4:0]        rd_addr_o,
    output hartid_t           hartid_o,
    output id_t               id_o
`ifdef GARUDA_DOTP_SAT_FLAG_EN
    ,
    output logic              sat_o,
    input  logic              sat_clr_i
`endif
);

    localparam int unsigned PROD_W  = 2 * ELEM_W;
    localparam int unsigned PRODS_W = NUM_LANES * PROD_W;
    localparam int unsigned SUM_W   = PROD_W + $clog2(NUM_LANES);

    // Handshake
    logic s1_valid;
    logic s1_adv;
    logic accept;
    logic rdy_en;

    // Stage 1 payload
    logic [PRODS_W-1:0] lane_prod;
    logic [PRODS_W-1:0] s1_prod;
    logic [XLEN-1:0]    s1_rd;
    opcode_t            s1_op;
    hartid_t            s1_hartid;
    id_t                s1_id;
    logic [4:0]         s1_rd_addr;

    // Stage 2 combinational datapath
    logic signed [SUM_W-1:0] sum;
    logic signed [XLEN:0]    full;
    logic signed [SAT_W-1:0] full_ext;
    logic signed [SAT_W-1:0] sat_full;
    logic signed [SAT_W-1:0] clip_full;
    logic [XLEN-1:0]         nxt_result;
    logic                    nxt_we;

    // in_ready_o stays low through reset and the first cycle after it.
    assign s1_adv     = !out_valid_o || out_ready_i;
    assign in_ready_o = rdy_en && (!s1_valid || s1_adv);
    assign accept     = in_valid_i && in_ready_o;

    int8_dotp_lane_mul #(
        .XLEN      (XLEN),
        .ELEM_W    (ELEM_W),
        .NUM_LANES (NUM_LANES)
    ) u_lane_mul (
        .a    (rs1_i),
        .b    (rs2_i),
        .prod (lane_prod)
    );

    // Stage 2 reduce, accumulate and round per opcode.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            sum = sum + SUM_W'(signed'(s1_prod[i*PROD_W +: PROD_W]));
        end
        full       = (XLEN+1)'(signed'(s1_rd)) + (XLEN+1)'(sum);
        full_ext   = SAT_W'(full);
        sat_full   = saturate(full_ext, XLEN);
        clip_full  = saturate(full_ext, 8);
        nxt_result = '0;
        nxt_we     = 1'b0;
        case (dotp_opcode_t'(s1_op))
            DOTP8: begin
                nxt_result = full[XLEN-1:0];
                nxt_we     = 1'b1;
            end
            DOTP8_SAT: begin
                nxt_result = sat_full[XLEN-1:0];
                nxt_we     = 1'b1;
            end
            DOTP8_CLIP: begin
                nxt_result = clip_full[XLEN-1:0];
                nxt_we     = 1'b1;
            end
            default: ;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdy_en      <= 1'b0;
            s1_valid    <= 1'b0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            we_o        <= 1'b0;
            rd_addr_o   <= '0;
            hartid_o    <= '0;
            id_o        <= '0;
        end else begin
            rdy_en   <= 1'b1;
            s1_valid <= accept || (s1_valid && !s1_adv);
            if (s1_adv) begin
                out_valid_o <= s1_valid;
                if (s1_valid) begin
                    result_o  <= nxt_result;
                    we_o      <= nxt_we;
                    rd_addr_o <= s1_rd_addr;
                    hartid_o  <= s1_hartid;
                    id_o      <= s1_id;
                end
            end
        end
    end

    // Stage 1 payload; qualified by s1_valid so no reset needed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_prod    <= lane_prod;
            s1_rd      <= rd_i;
            s1_op      <= opcode_i;
            s1_hartid  <= hartid_i;
            s1_id      <= id_i;
            s1_rd_addr <= rd_addr_i;
        end
    end

`ifdef GARUDA_DOTP_SAT_FLAG_EN
    logic nxt_clamped;
    logic s2_clamped;

    always_comb begin
        nxt_clamped = 1'b0;
        case (dotp_opcode_t'(s1_op))
            DOTP8_SAT:  nxt_clamped = (sat_full != full_ext);
            DOTP8_CLIP: nxt_clamped = (clip_full != full_ext);
            default: ;
        endcase
    end

    // Sticky saturation flag; a retiring clamp beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_clamped <= 1'b0;
            sat_o      <= 1'b0;
        end else begin
            if (s1_adv && s1_valid) begin
                s2_clamped <= nxt_clamped;
            end
            if (out_valid_o && out_ready_i && s2_clamped) begin
                sat_o <= 1'b1;
            end else if (sat_clr_i) begin
                sat_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_int8_dotp_unit.sv
// -----------------------------------------------------------------------------
// tb_int8_dotp_unit
// Self-checking bench for int8_dotp_unit: directed vectors, backpressure,
// mid-operation reset and a randomized stream against a behavioural model.
// -----------------------------------------------------------------------------
module tb_int8_dotp_unit;
    import int8_dotp_instr_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [31:0]  rs1_i, rs2_i, rd_i;
    dotp_opcode_t opcode_i;
    logic [1:0]   hartid_i;
    logic [2:0]   id_i;
    logic [4:0]   rd_addr_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  result_o;
    logic         we_o;
    logic [4:0]   rd_addr_o;
    logic [1:0]   hartid_o;
    logic [2:0]   id_o;
`ifdef GARUDA_DOTP_SAT_FLAG_EN
    logic         sat_o;
    logic         sat_clr_i;
    bit           sat_model;
`endif

    always #5 clk_i = ~clk_i;

    int8_dotp_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rd_i        (rd_i),
        .opcode_i    (opcode_i),
        .hartid_i    (hartid_i),
        .id_i        (id_i),
        .rd_addr_i   (rd_addr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .we_o        (we_o),
        .rd_addr_o   (rd_addr_o),
        .hartid_o    (hartid_o),
        .id_o        (id_o)
`ifdef GARUDA_DOTP_SAT_FLAG_EN
        ,
        .sat_o       (sat_o),
        .sat_clr_i   (sat_clr_i)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic over the four signed byte lanes.
    function automatic logic [31:0] ref_dotp(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input dotp_opcode_t op,
                                             output logic we, output bit clamped);
        longint s, full, r, maxv, minv;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(a[8*i +: 8])) * longint'($signed(b[8*i +: 8]));
        end
        full = longint'($signed(c)) + s;
        maxv = (longint'(1) <<< 31) - 1;
        minv = -(longint'(1) <<< 31);
        we   = 1'b1;
        r    = full;
        case (op)
            DOTP8:      r = full;
            DOTP8_SAT:  r = (full > maxv) ? maxv : (full < minv) ? minv : full;
            DOTP8_CLIP: r = (full > INT8_MAX) ? longint'(INT8_MAX) :
                            (full < INT8_MIN) ? longint'(INT8_MIN) : full;
            default: begin
                r  = 0;
                we = 1'b0;
            end
        endcase
        clamped = ((op == DOTP8_SAT) || (op == DOTP8_CLIP)) && (r != full);
        return r[31:0];
    endfunction

    typedef struct {
        logic [31:0] result;
        logic        we;
        logic [4:0]  addr;
        logic [1:0]  hart;
        logic [2:0]  id;
        bit          clamped;
        int          acc_cyc;
        bit          disturbed;
    } exp_t;

    exp_t exp_q[$];

    // out_ready_i driver: 0 = stall, 1 = always ready, 2 = random.
    int ready_mode = 1;
    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       out_ready_i = 1'b0;
            1:       out_ready_i = 1'b1;
            default: out_ready_i = ($urandom_range(0, 3) != 0);
        endcase
`ifdef GARUDA_DOTP_SAT_FLAG_EN
        sat_clr_i = (ready_mode == 2) && ($urandom_range(0, 7) == 0);
`endif
    end

    // Compare process: sampled on the falling edge, where inputs and outputs
    // describe the handshakes of the coming rising edge.
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_res;
    logic [10:0] prev_meta;
    exp_t        e;
    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            exp_q.delete();
            prev_stall = 0;
`ifdef GARUDA_DOTP_SAT_FLAG_EN
            sat_model = 0;
`endif
        end else begin
            bit clamp_ret;
            clamp_ret = 0;
            if (prev_stall) begin
                check("hold_valid", longint'(out_valid_o), 1);
                check("hold_result", longint'(result_o), longint'(prev_res));
                check("hold_meta", longint'({we_o, rd_addr_o, hartid_o, id_o}), longint'(prev_meta));
            end
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_valid: out_valid_o=1 with no op in flight at %0t", $time);
                end else if (out_ready_i) begin
                    e = exp_q.pop_front();
                    check("result", longint'(result_o), longint'(e.result));
                    check("we", longint'(we_o), longint'(e.we));
                    check("meta", longint'({rd_addr_o, hartid_o, id_o}),
                          longint'({e.addr, e.hart, e.id}));
                    if (!e.disturbed) check("latency", longint'(cyc - e.acc_cyc), 2);
                    clamp_ret = e.clamped;
                end
            end
`ifdef GARUDA_DOTP_SAT_FLAG_EN
            check("sat_flag", longint'(sat_o), longint'(sat_model));
            sat_model = clamp_ret || (sat_model && !sat_clr_i);
`endif
            if (!out_ready_i) begin
                foreach (exp_q[i]) exp_q[i].disturbed = 1;
            end
            if (in_valid_i && in_ready_o) begin
                exp_t n;
                n.result    = ref_dotp(rs1_i, rs2_i, rd_i, opcode_i, n.we, n.clamped);
                n.addr      = rd_addr_i;
                n.hart      = hartid_i;
                n.id        = id_i;
                n.acc_cyc   = cyc;
                n.disturbed = 0;
                exp_q.push_back(n);
            end
            if (exp_q.size() > 2) check("in_flight_le_2", longint'(exp_q.size()), 2);
            prev_stall = out_valid_o && !out_ready_i;
            prev_res   = result_o;
            prev_meta  = {we_o, rd_addr_o, hartid_o, id_o};
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input dotp_opcode_t op, input logic [1:0] h, input logic [2:0] i,
                        input logic [4:0] ad);
        int w;
        rs1_i = a; rs2_i = b; rd_i = c; opcode_i = op;
        hartid_i = h; id_i = i; rd_addr_i = ad;
        in_valid_i = 1'b1;
        w = 0;
        do begin
            @(negedge clk_i);
            w++;
        end while (!in_ready_o && w < 100);
        if (!in_ready_o) check("send_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid_o) && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        check(name, longint'(exp_q.size()), 0);
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 5))
                0:       w[8*i +: 8] = 8'h00;
                1:       w[8*i +: 8] = 8'h7F;
                2:       w[8*i +: 8] = 8'h80;
                3:       w[8*i +: 8] = 8'h81;
                4:       w[8*i +: 8] = 8'hFF;
                default: w[8*i +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] rand_acc();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom);
            1:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            2:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
            default: return 32'($signed(10'($urandom)));
        endcase
    endfunction

    typedef struct {
        logic [31:0]  a, b, c;
        dotp_opcode_t op;
        logic [31:0]  res;
        logic         we;
    } vec_t;

    vec_t vecs[9] = '{
        '{32'h0403_0201, 32'h0101_0101, 32'd10,          DOTP8,      32'd20,          1'b1},
        '{32'hFFFF_FFFF, 32'h0202_0202, 32'd0,           DOTP8,      32'hFFFF_FFF8,   1'b1},
        '{32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FF00,   DOTP8,      32'h8000_FB04,   1'b1},
        '{32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FF00,   DOTP8_SAT,  32'h7FFF_FFFF,   1'b1},
        '{32'h8181_8181, 32'h7F7F_7F7F, 32'h8000_0000,   DOTP8_SAT,  32'h8000_0000,   1'b1},
        '{32'h8080_8080, 32'h8080_8080, 32'd0,           DOTP8_CLIP, 32'd127,         1'b1},
        '{32'h0000_00C0, 32'h0000_0002, 32'hFFFF_FFFF,   DOTP8_CLIP, 32'hFFFF_FF80,   1'b1},
        '{32'h0000_0005, 32'h0000_0003, 32'd10,          DOTP8_CLIP, 32'd25,          1'b1},
        '{32'h0102_0304, 32'h0506_0708, 32'd0,           ILLEGAL,    32'd0,           1'b0}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we_m;
        bit          cl_m;
        logic [31:0] r_m;
        int          w;

        rst_i = 1'b1; in_valid_i = 1'b0;
        rs1_i = '0; rs2_i = '0; rd_i = '0; opcode_i = ILLEGAL;
        hartid_i = '0; id_i = '0; rd_addr_i = '0;
        out_ready_i = 1'b0;
`ifdef GARUDA_DOTP_SAT_FLAG_EN
        sat_clr_i = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_out_valid", longint'(out_valid_o), 0);
        check("rst_in_ready", longint'(in_ready_o), 0);
        check("rst_result", longint'(result_o), 0);
        check("rst_we", longint'(we_o), 0);
        check("rst_meta", longint'({rd_addr_o, hartid_o, id_o}), 0);
`ifdef GARUDA_DOTP_SAT_FLAG_EN
        check("rst_sat", longint'(sat_o), 0);
`endif
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("in_ready_after_rst", longint'(in_ready_o), 1);

        // Pin the model to hand-computed values, then run each vector.
        foreach (vecs[i]) begin
            r_m = ref_dotp(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op, we_m, cl_m);
            check("pin_result", longint'(r_m), longint'(vecs[i].res));
            check("pin_we", longint'(we_m), longint'(vecs[i].we));
            send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op,
                 2'(i), 3'(i), 5'(i + 3));
        end
        wait_drain("directed_drain");

        // Backpressure: two accepts fill the pipe, third waits.
        ready_mode = 0;
        @(posedge clk_i); #1;
        fork
            begin
                send(32'h0403_0201, 32'h0101_0101, 32'd1, DOTP8,      2'd1, 3'd1, 5'd11);
                send(32'h8080_8080, 32'h8080_8080, 32'd0, DOTP8_CLIP, 2'd2, 3'd2, 5'd12);
                send(32'h1111_1111, 32'h2222_2222, 32'd5, ILLEGAL,    2'd3, 3'd3, 5'd13);
            end
            begin
                repeat (6) @(negedge clk_i);
                check("bp_in_ready_low", longint'(in_ready_o), 0);
                check("bp_out_valid", longint'(out_valid_o), 1);
                ready_mode = 1;
                w = 0;
                do begin
                    @(negedge clk_i);
                    w++;
                end while (!(out_valid_o && out_ready_i) && w < 20);
                check("bp_first_retire", longint'(out_valid_o && out_ready_i), 1);
                repeat (2) begin
                    @(negedge clk_i);
                    check("bp_consecutive_retire", longint'(out_valid_o && out_ready_i), 1);
                end
            end
        join
        wait_drain("bp_drain");

        // Reset with two ops in flight.
        ready_mode = 0;
        @(posedge clk_i); #1;
        send(32'h0101_0101, 32'h0101_0101, 32'd7, DOTP8, 2'd0, 3'd4, 5'd20);
        send(32'h0202_0202, 32'h0101_0101, 32'd9, DOTP8, 2'd1, 3'd5, 5'd21);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_flush_valid", longint'(out_valid_o), 0);
        ready_mode = 1;
        @(posedge clk_i); #1;
        send(32'h0000_0005, 32'h0000_0003, 32'd10, DOTP8_CLIP, 2'd2, 3'd6, 5'd22);
        wait_drain("rst_new_op_drain");

        // Randomized stream with random backpressure.
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            send(rand_word(), rand_word(), rand_acc(),
                 dotp_opcode_t'($urandom_range(0, 3)),
                 2'($urandom), 3'($urandom), 5'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i); #1;
            end
        end
        ready_mode = 1;
        wait_drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int8_dotp_unit.md
Name: int8_dotp_unit

Overview:
- Parametrised successor to the single-lane INT8 MAC execution unit.
- Computes a signed packed-SIMD dot product of NUM_LANES 8-bit lanes from rs1/rs2, accumulates it into rd, and applies wrap, 32-bit saturate or int8 clip.
- 2-stage pipeline with valid/ready handshake on both sides; sits behind the coprocessor issue interface and feeds the writeback arbiter.
- Carries hartid/id/rd_addr metadata alongside each result.

Parameters:
- XLEN, 32, operand/result width; must be a multiple of ELEM_W.
- ELEM_W, 8, lane width in bits.
- NUM_LANES, XLEN/ELEM_W, lanes used (1..XLEN/ELEM_W; low lanes first).
- opcode_t, dotp_opcode_t, opcode enum type.
- hartid_t, logic [1:0], hart id type.
- id_t, logic [2:0], instruction id type.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when valid & ready
- rs1_i  in  XLEN  packed lanes A
- rs2_i  in  XLEN  packed lanes B
- rd_i  in  XLEN  accumulator input
- opcode_i  in  opcode_t  operation
- hartid_i  in  hartid_t  metadata
- id_i  in  id_t  metadata
- rd_addr_i  in  5  destination register
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer ready
- result_o  out  XLEN  result
- we_o  out  1  write-enable qualifier
- rd_addr_o  out  5  metadata echo
- hartid_o  out  hartid_t  metadata echo
- id_o  out  id_t  metadata echo

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: all outputs are 0 except in_ready_o, which is 1 one cycle after reset deasserts. Both stage-valid bits are cleared; any in-flight operations are discarded, none are emitted.
- Stage 1, on accept: registers the NUM_LANES signed 16-bit lane products a_i*b_i, plus rd, opcode and metadata.
- Stage 2: computes sum = sign-extended adder tree of the products (16+clog2(NUM_LANES) bits), then full = sext(rd) + sext(sum) at XLEN+1 bits.
  - DOTP8: result = full[XLEN-1:0] (wraps).
  - DOTP8_SAT: result = full clamped to the signed XLEN range.
  - DOTP8_CLIP: result = full clamped to [-128,127], sign-extended to XLEN.
  - ILLEGAL/other: result 0, we_o=0, out_valid_o still asserted so the id retires.
  - we_o=1 for all legal opcodes.
- Handshake:
  - s1_adv = !s2_valid | out_ready_i.
  - in_ready_o = !s1_valid | s1_adv.
  - Throughput is 1 op/cycle; latency is 2 cycles from accept to out_valid_o.
- Under out_ready_i=0, all outputs hold stable while out_valid_o=1. At most 2 ops are in flight, and they complete in order.
- Simultaneous accept and output retire in the same cycle: no bubble is inserted.
- in_valid_i with in_ready_o=0: inputs are ignored and the request must be held by the source.

Optional Feature:
- GARUDA_DOTP_SAT_FLAG_EN adds port sat_o (out, 1) and port sat_clr_i (in, 1).
- sat_o is a sticky flag, set when a DOTP8_SAT or DOTP8_CLIP result that actually clamped is retired (out_valid_o & out_ready_i).
- sat_clr_i clears the flag. If clear and set occur in the same cycle, set wins. Reset value is 0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- int8_dotp_instr_pkg holds:
  - dotp_opcode_t {ILLEGAL, DOTP8, DOTP8_SAT, DOTP8_CLIP}
  - the INT8_MIN/INT8_MAX constants
  - the opcode_to_string function
  - a saturate function parametrised by target width
- One sub-module, int8_dotp_lane_mul: a combinational array of NUM_LANES signed multipliers, instantiated in stage 1.

Test Plan:
- DOTP8 basic: rs1=0x04030201, rs2=0x01010101, rd=10 -> result=20, we_o=1, 2 cycles after accept; metadata echoed.
- DOTP8 negative and wrap:
  - rs1=0xFFFFFFFF, rs2=0x02020202, rd=0 -> 0xFFFFFFF8.
  - rs1=rs2=0x7F7F7F7F, rd=0x7FFFFF00 -> 0x8000FB04.
- DOTP8_SAT with the same overflow operands -> 0x7FFFFFFF; with rd=0x80000000 and rs1=0x81818181, rs2=0x7F7F7F7F -> 0x80000000.
- DOTP8_CLIP:
  - rs1=rs2=0x80808080, rd=0 -> 127 (sum 65536).
  - rs1=0x000000C0, rs2=0x00000002, rd=-1 -> -128.
  - rs1=0x00000005, rs2=0x00000003, rd=10 -> 25.
- Backpressure: hold out_ready_i=0 and stream 3 ops.
  - in_ready_o drops after 2 accepts; result_o is stable while stalled.
  - On release, 3 results retire in order on consecutive cycles.
  - ILLEGAL retires with we_o=0.
- Reset mid-operation: assert rst_i for 1 cycle with 2 ops in flight -> out_valid_o=0 the next cycle, no stale result ever emitted, and a new op completes with correct latency afterward.
